// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized and stable lock,
// then releases the system reset. Lock loss or a lock timeout re-runs the sequence.
module pll_reset_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 8,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_count
);

    localparam logic [23:0] PllRstLast  = 24'(PLL_RST_CYCLES - 1);
    localparam logic [23:0] TimeoutLast = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] StableLast  = 24'(STABLE_CYCLES - 1);
    localparam logic [23:0] HoldLast    = 24'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        StPllRst,
        StWaitLock,
        StStable,
        StHold,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [23:0]            cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic [7:0]             relock_q, relock_d;
    logic                   relock_inc;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 24'd1;
        relock_inc = 1'b0;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == PllRstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s) state_d = StStable;
                else if (cnt_q == TimeoutLast) state_d = StPllRst;
            end
            StStable: begin
                // Lock loss wins over a completed stable window.
                if (!locked_s) state_d = StWaitLock;
                else if (cnt_q == StableLast) state_d = StHold;
            end
            StHold: begin
                if (!locked_s) state_d = StWaitLock;
                else if (cnt_q == HoldLast) state_d = StRun;
            end
            StRun: begin
                if (!locked_s) begin
                    state_d    = StWaitLock;
                    relock_inc = 1'b1;
                end
            end
            default: state_d = StPllRst;
        endcase

        if (state_d != state_q) cnt_d = 24'd0;

        // Outputs are registered from the next state so they change on the transition edge.
        pll_rst_d   = (state_d == StPllRst);
        sys_reset_d = (state_d != StRun);
        ready_d     = (state_d == StRun);
        relock_d    = relock_q;
        if (relock_inc && (relock_q != 8'hFF)) relock_d = relock_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StPllRst;
            cnt_q       <= 24'd0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            relock_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            relock_q    <= relock_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset    = sys_reset_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters; edge_n counts
// rising edges since reset release and outputs are sampled 1 ns after each edge.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;

    int         errors = 0;
    int         checks = 0;
    int         edge_n = 0;
    logic [7:0] exp_relock;

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(8),
        .STABLE_CYCLES (16),
        .HOLD_CYCLES   (4),
        .LOCK_TIMEOUT  (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .relock_count(relock_count)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic start_seq(input logic lock);
        reset      = 1'b1;
        pll_locked = lock;
        tick();
        tick();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pll_locked = 1'b1;
        tick();
        tick();
        checks += 4;
        if (pll_rst !== 1'b1) begin
            errors++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst);
        end
        if (sys_reset !== 1'b1) begin
            errors++; $display("FAIL reset_sys_reset: got %b want 1", sys_reset);
        end
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", ready);
        end
        if (relock_count !== 8'd0) begin
            errors++; $display("FAIL reset_relock: got %0d want 0", relock_count);
        end
    endtask

    task automatic test_clean_start();
        start_seq(1'b1);
        for (int n = 1; n <= 29; n++) begin
            tick();
            checks += 3;
            if (pll_rst !== (edge_n < 8)) begin
                errors++;
                $display("FAIL clean_pll_rst edge %0d: got %b want %b", edge_n, pll_rst, edge_n < 8);
            end
            if (ready !== (edge_n >= 29)) begin
                errors++;
                $display("FAIL clean_ready edge %0d: got %b want %b", edge_n, ready, edge_n >= 29);
            end
            if (sys_reset !== (edge_n < 29)) begin
                errors++;
                $display("FAIL clean_sys_reset edge %0d: got %b want %b", edge_n, sys_reset,
                         edge_n < 29);
            end
        end
        checks++;
        if (relock_count !== 8'd0) begin
            errors++; $display("FAIL clean_relock: got %0d want 0", relock_count);
        end
    endtask

    task automatic test_no_lock();
        start_seq(1'b0);
        for (int n = 1; n <= 230; n++) begin
            tick();
            // Pulses start after edges 72, 144, 216 (period 8 + 64) and after reset.
            checks += 2;
            if (pll_rst !== ((edge_n % 72) < 8)) begin
                errors++;
                $display("FAIL nolock_pll_rst edge %0d: got %b want %b", edge_n, pll_rst,
                         (edge_n % 72) < 8);
            end
            if (sys_reset !== 1'b1) begin
                errors++;
                $display("FAIL nolock_sys_reset edge %0d: got %b want 1", edge_n, sys_reset);
            end
        end
    endtask

    task automatic test_chatter();
        start_seq(1'b0);
        run_to(10);
        pll_locked = 1'b1;  // seen by WAIT_LOCK at edge 13
        run_to(20);
        pll_locked = 1'b0;  // STABLE exits at edge 23
        run_to(23);
        pll_locked = 1'b1;  // STABLE re-entered at edge 26, RUN at 46
        run_to(33);
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL chatter_ready_early edge 33: got %b want 0", ready);
        end
        run_to(45);
        checks += 2;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL chatter_ready_45: got %b want 0", ready);
        end
        if (sys_reset !== 1'b1) begin
            errors++; $display("FAIL chatter_sys_reset_45: got %b want 1", sys_reset);
        end
        tick();
        checks += 4;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL chatter_ready_46: got %b want 1", ready);
        end
        if (sys_reset !== 1'b0) begin
            errors++; $display("FAIL chatter_sys_reset_46: got %b want 0", sys_reset);
        end
        if (pll_rst !== 1'b0) begin
            errors++; $display("FAIL chatter_pll_rst_46: got %b want 0", pll_rst);
        end
        if (relock_count !== 8'd0) begin
            errors++; $display("FAIL chatter_relock: got %0d want 0", relock_count);
        end
    endtask

    task automatic test_lock_loss_run();
        run_to(50);
        pll_locked = 1'b0;  // k = 51
        tick();
        tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL loss_ready_k1: got %b want 1", ready);
        end
        tick();
        checks += 3;
        if (sys_reset !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL loss_outputs_k2: got sys_reset=%b ready=%b want 1/0", sys_reset, ready);
        end
        if (relock_count !== 8'd1) begin
            errors++; $display("FAIL loss_relock: got %0d want 1", relock_count);
        end
        if (pll_rst !== 1'b0) begin
            errors++; $display("FAIL loss_pll_rst: got %b want 0", pll_rst);
        end
        run_to(55);
        pll_locked = 1'b1;  // STABLE at edge 58, RUN at 78
        while (edge_n < 77) begin
            tick();
            checks++;
            if (pll_rst !== 1'b0) begin
                errors++; $display("FAIL loss_pll_rst edge %0d: got %b want 0", edge_n, pll_rst);
            end
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL loss_ready_77: got %b want 0", ready);
        end
        tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL loss_ready_78: got %b want 1", ready);
        end
        exp_relock = 8'd1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            int waited;
            pll_locked = 1'b0;
            tick();
            tick();
            tick();
            if (exp_relock != 8'hFF) exp_relock = exp_relock + 8'd1;
            checks++;
            if (relock_count !== exp_relock) begin
                errors++;
                $display("FAIL sat_relock iter %0d: got %0d want %0d", i, relock_count, exp_relock);
            end
            pll_locked = 1'b1;
            waited = 0;
            while (ready !== 1'b1 && waited < 40) begin
                tick();
                waited++;
            end
            if (ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL sat_relock_timeout iter %0d: ready=%b want 1", i, ready);
                break;
            end
        end
        checks++;
        if (relock_count !== 8'd255) begin
            errors++; $display("FAIL sat_final: got %0d want 255", relock_count);
        end
    endtask

    task automatic test_mid_reset();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL midrst_precondition: ready=%b want 1", ready);
        end
        reset = 1'b1;
        tick();
        checks += 4;
        if (pll_rst !== 1'b1) begin
            errors++; $display("FAIL midrst_pll_rst: got %b want 1", pll_rst);
        end
        if (sys_reset !== 1'b1) begin
            errors++; $display("FAIL midrst_sys_reset: got %b want 1", sys_reset);
        end
        if (ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready: got %b want 0", ready);
        end
        if (relock_count !== 8'd0) begin
            errors++; $display("FAIL midrst_relock: got %0d want 0", relock_count);
        end
        reset  = 1'b0;
        edge_n = 0;
        for (int n = 1; n <= 29; n++) begin
            tick();
            checks += 2;
            if (pll_rst !== (edge_n < 8)) begin
                errors++;
                $display("FAIL midrst_pll_rst edge %0d: got %b want %b", edge_n, pll_rst,
                         edge_n < 8);
            end
            if (ready !== (edge_n >= 29)) begin
                errors++;
                $display("FAIL midrst_ready edge %0d: got %b want %b", edge_n, ready,
                         edge_n >= 29);
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        exp_relock = 8'd0;
        test_reset();
        test_clean_start();
        test_no_lock();
        test_chatter();
        test_lock_loss_run();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
